// File: rtl/reg_bank_16x64.sv
// Sixteen-entry operand register file with one merging write port and two
// independently registered read ports, each able to load a register or a constant.
module reg_bank_16x64 #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             regwen,
  input  logic [WIDTH-1:0] inA,
  input  logic [3:0]       selwreg,
  input  logic [1:0]       endreg,
  output logic [WIDTH-1:0] outA,
  output logic [WIDTH-1:0] outB,
  input  logic [3:0]       seloutA,
  input  logic [3:0]       seloutB,
  input  logic             cnstA,
  input  logic             cnstB,
  input  logic             enrregA,
  input  logic             enrregB
);

  localparam int H = WIDTH / 2;

  logic [WIDTH-1:0] bank_q [16];
  logic [WIDTH-1:0] bank_d [16];
  logic [WIDTH-1:0] outA_q, outA_d;
  logic [WIDTH-1:0] outB_q, outB_d;

  // endreg: 00 full word, 10 low half, 01 high half, 11 halves swapped
  function automatic logic [WIDTH-1:0] merge_write(
    input logic [WIDTH-1:0] old_val,
    input logic [WIDTH-1:0] data,
    input logic [1:0]       mode
  );
    logic [WIDTH-1:0] res;
    case (mode)
      2'b00:   res = data;
      2'b10:   res = {old_val[WIDTH-1:H], data[H-1:0]};
      2'b01:   res = {data[WIDTH-1:H], old_val[H-1:0]};
      default: res = {data[H-1:0], data[WIDTH-1:H]};
    endcase
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] zext_sel(input logic [3:0] sel);
    return {{(WIDTH-4){1'b0}}, sel};
  endfunction

  function automatic logic [WIDTH-1:0] read_src(
    input logic             cnst,
    input logic [3:0]       sel,
    input logic [WIDTH-1:0] reg_val
  );
    return cnst ? zext_sel(sel) : reg_val;
  endfunction

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      bank_d[i] = bank_q[i];
    end
    if (regwen) begin
      bank_d[selwreg] = merge_write(bank_q[selwreg], inA, endreg);
    end
  end

  // Reads sample the pre-edge bank, so a same-edge write is not bypassed
  always_comb begin
    outA_d = outA_q;
    outB_d = outB_q;
    if (enrregA) begin
      outA_d = read_src(cnstA, seloutA, bank_q[seloutA]);
    end
    if (enrregB) begin
      outB_d = read_src(cnstB, seloutB, bank_q[seloutB]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        bank_q[i] <= '0;
      end
      outA_q <= '0;
      outB_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        bank_q[i] <= bank_d[i];
      end
      outA_q <= outA_d;
      outB_q <= outB_d;
    end
  end

  assign outA = outA_q;
  assign outB = outB_q;

endmodule

// File: tb/tb_reg_bank_16x64.sv
// Directed bench for reg_bank_16x64: write modes, constant/hold reads,
// same-edge read/write ordering and asynchronous reset.
module tb_reg_bank_16x64;

  logic        clock;
  logic        reset_n;
  logic        regwen;
  logic [63:0] inA;
  logic [3:0]  selwreg;
  logic [1:0]  endreg;
  logic [63:0] outA;
  logic [63:0] outB;
  logic [3:0]  seloutA;
  logic [3:0]  seloutB;
  logic        cnstA;
  logic        cnstB;
  logic        enrregA;
  logic        enrregB;

  int errors = 0;
  int checks = 0;

  reg_bank_16x64 #(.WIDTH(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .regwen  (regwen),
    .inA     (inA),
    .selwreg (selwreg),
    .endreg  (endreg),
    .outA    (outA),
    .outB    (outB),
    .seloutA (seloutA),
    .seloutB (seloutB),
    .cnstA   (cnstA),
    .cnstB   (cnstB),
    .enrregA (enrregA),
    .enrregB (enrregB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [1:0] mode, input logic [63:0] data);
    regwen  = 1'b1;
    selwreg = sel;
    endreg  = mode;
    inA     = data;
    tick();
    regwen  = 1'b0;
  endtask

  task automatic rd_a(input logic [3:0] sel);
    cnstA   = 1'b0;
    seloutA = sel;
    enrregA = 1'b1;
    tick();
    enrregA = 1'b0;
  endtask

  task automatic rd_b(input logic [3:0] sel);
    cnstB   = 1'b0;
    seloutB = sel;
    enrregB = 1'b1;
    tick();
    enrregB = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    regwen  = 1'b0;
    inA     = '0;
    selwreg = '0;
    endreg  = '0;
    seloutA = '0;
    seloutB = '0;
    cnstA   = 1'b0;
    cnstB   = 1'b0;
    enrregA = 1'b0;
    enrregB = 1'b0;

    #3;
    check("reset_outA", outA, 64'h0);
    check("reset_outB", outB, 64'h0);
    tick();
    reset_n = 1'b1;
    tick();

    wr(4'd3, 2'b00, 64'h00000000_00FF00FF);
    rd_a(4'd3);
    check("full_write_R3", outA, 64'h00000000_00FF00FF);

    wr(4'd5, 2'b00, 64'h11112222_33334444);
    wr(4'd5, 2'b10, 64'hAAAABBBB_CCCCDDDD);
    rd_a(4'd5);
    check("low_half_R5", outA, 64'h11112222_CCCCDDDD);
    wr(4'd5, 2'b01, 64'hAAAABBBB_CCCCDDDD);
    rd_a(4'd5);
    check("high_half_R5", outA, 64'hAAAABBBB_CCCCDDDD);

    wr(4'd7, 2'b11, 64'h12345678_9ABCDEF0);
    rd_b(4'd7);
    check("swap_R7", outB, 64'h9ABCDEF0_12345678);

    // constant on A while B reads a register
    cnstA = 1'b1; seloutA = 4'hC; enrregA = 1'b1;
    cnstB = 1'b0; seloutB = 4'd3; enrregB = 1'b1;
    tick();
    check("const_A_C", outA, 64'h0C);
    check("indep_B_R3", outB, 64'h00000000_00FF00FF);
    enrregA = 1'b0; cnstA = 1'b0; seloutA = 4'd5;
    seloutB = 4'd5;
    tick();
    check("hold_A_1", outA, 64'h0C);
    check("indep_B_R5", outB, 64'hAAAABBBB_CCCCDDDD);
    seloutA = 4'd7; cnstA = 1'b1;
    enrregB = 1'b0; seloutB = 4'd7;
    tick();
    check("hold_A_2", outA, 64'h0C);
    check("hold_B", outB, 64'hAAAABBBB_CCCCDDDD);
    cnstB = 1'b1; seloutB = 4'hF; enrregB = 1'b1;
    tick();
    enrregB = 1'b0; cnstB = 1'b0;
    check("const_B_F", outB, 64'h0F);

    // same-edge write and read of R2 returns the old value
    wr(4'd2, 2'b00, 64'h1);
    regwen = 1'b1; selwreg = 4'd2; endreg = 2'b00; inA = 64'h2;
    cnstA = 1'b0; seloutA = 4'd2; enrregA = 1'b1;
    tick();
    regwen = 1'b0;
    check("same_edge_old", outA, 64'h1);
    tick();
    enrregA = 1'b0;
    check("next_edge_new", outA, 64'h2);

    wr(4'd0, 2'b00, 64'hDEADBEEF_CAFEF00D);
    cnstA = 1'b0; seloutA = 4'd0; enrregA = 1'b1;
    cnstB = 1'b0; seloutB = 4'd0; enrregB = 1'b1;
    tick();
    enrregA = 1'b0; enrregB = 1'b0;
    check("R0_portA", outA, 64'hDEADBEEF_CAFEF00D);
    check("R0_portB", outB, 64'hDEADBEEF_CAFEF00D);

    regwen = 1'b0; selwreg = 4'd0; endreg = 2'b00; inA = 64'h5555_5555_5555_5555;
    tick();
    rd_a(4'd0);
    check("no_write_when_regwen0", outA, 64'hDEADBEEF_CAFEF00D);

    // reset asserted mid-cycle during a pending write to R9
    regwen = 1'b1; selwreg = 4'd9; endreg = 2'b00; inA = 64'h9999_9999_9999_9999;
    enrregA = 1'b1; seloutA = 4'd3; enrregB = 1'b1; seloutB = 4'd7;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outA", outA, 64'h0);
    check("async_reset_outB", outB, 64'h0);
    tick();
    check("in_reset_outA", outA, 64'h0);
    regwen = 1'b0; enrregA = 1'b0; enrregB = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cnstA = 1'b0; seloutA = 4'(i); enrregA = 1'b1;
      cnstB = 1'b0; seloutB = 4'(15 - i); enrregB = 1'b1;
      tick();
      check($sformatf("post_reset_A_R%0d", i), outA, 64'h0);
      check($sformatf("post_reset_B_R%0d", 15 - i), outB, 64'h0);
    end
    enrregA = 1'b0; enrregB = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_16x64.md
# reg_bank_16x64

Register file of sixteen 64-bit registers with one write port and two independently registered read ports (A and B). The write port supports full-word, half-word and half-swapped writes. Each read port can load either a register's contents or a constant. It is the operand store of the datapath: outA and outB feed the execution unit, and inA receives results.

## Interface
Parameters:
- WIDTH, 64, register and port data width; must be even; half-word is WIDTH/2.

Ports:
- clock  in  1  master clock, active on rising edge.
- reset_n  in  1  asynchronous reset, active low.
- regwen  in  1  write enable; 1 writes register selwreg at the next rising edge.
- inA  in  WIDTH  write data.
- selwreg  in  4  write register index, 0–15.
- endreg  in  2  write mode; see Operation.
- outA  out  WIDTH  read port A, registered.
- outB  out  WIDTH  read port B, registered.
- seloutA  in  4  register index for port A.
- seloutB  in  4  register index for port B.
- cnstA  in  1  port A source: 0 = register bank, 1 = constant.
- cnstB  in  1  port B source: 0 = register bank, 1 = constant.
- enrregA  in  1  load enable for outA.
- enrregB  in  1  load enable for outB.

## Operation
Register bank:
- R0–R15, each WIDTH bits.
- R0 is an ordinary register and is writable.

Write, when regwen = 1 at a rising clock edge, for R = R[selwreg] (H = WIDTH/2):
- endreg 00: R ← inA.
- endreg 10: R[H-1:0] ← inA[H-1:0]; the high half is unchanged.
- endreg 01: R[WIDTH-1:H] ← inA[WIDTH-1:H]; the low half is unchanged.
- endreg 11: R ← {inA[H-1:0], inA[WIDTH-1:H]}, i.e. inA with its halves swapped.
- When regwen = 0, no register changes; endreg, selwreg and inA are don't-care.

Read, on a rising edge:
- enrregA = 1: outA ← (cnstA ? zero-extended seloutA : R[seloutA]).
- enrregB = 1: outB ← (cnstB ? zero-extended seloutB : R[seloutB]).
- An enable at 0 holds that output.
- Ports A and B are fully independent and may select the same register.

Simultaneous events:
- A read and a write of the same register in the same cycle return the pre-write value (no write-through bypass).
- The new value is readable from the following cycle.

Reset (reset_n = 0, asynchronous):
- All sixteen registers, outA and outB clear to 0 immediately, without waiting for a clock edge.
- Writes and loads are ignored while reset is asserted.
- Reset asserted in the middle of a write sequence discards that write.
- Deassertion is synchronised by the user; after release, the first rising edge acts normally.

## Timing
- Write: data is captured at the rising edge where regwen = 1 and is visible in the bank after that edge.
- Read: outA/outB update at the rising edge where the enable = 1; latency is 1 cycle from select/enable to output.
- Write followed by read of the same register:
  - Earliest: regwen at edge N, enrreg at edge N+1; outX shows the new value after edge N+1.
  - Same edge N: outX shows the old value.
- No handshake; every operation completes in one cycle, with throughput of one write plus two reads per cycle.
- Outputs change only on a clock edge or on asynchronous reset.

## Test plan
- Reset: pulse reset_n low mid-cycle → outA, outB = 0 immediately; after release, reading R0–R15 on both ports gives 0.
- Full write and readback:
  - Stimulus: write R3 = 64'h00000000_00FF00FF with endreg 00; next cycle seloutA = 3, enrregA = 1.
  - Response: outA = 64'h00000000_00FF00FF.
- Half writes on R5:
  - Stimulus: write 64'h11112222_33334444 with endreg 00; then 64'hAAAABBBB_CCCCDDDD with endreg 10.
  - Response: R5 reads 64'h11112222_CCCCDDDD.
  - Stimulus: write the same data with endreg 01.
  - Response: R5 reads 64'hAAAABBBB_CCCCDDDD.
- Swap: write R7 = 64'h12345678_9ABCDEF0 with endreg 11 → outB (seloutB = 7) = 64'h9ABCDEF0_12345678.
- Constants and hold:
  - cnstA = 1, seloutA = 4'hC, enrregA = 1 → outA = 64'h0C.
  - Then enrregA = 0 with changing seloutA → outA holds 64'h0C.
  - Simultaneously, port B reads a register → correct value, showing the ports are independent.
- Same-cycle read/write: R2 = 64'h1; at one edge write R2 = 64'h2 and read port A from R2 → outA = 64'h1; next read → 64'h2.
